cc_line_deserializer: RTL and testbench

- Receive side of the cache-controller line path; the counterpart of the serializer that feeds the data reorder unit.
- Collects one critical-word-first, wrapping 8-beat AXI R burst from memory on a cache miss.
- Rebuilds the 512-bit line in natural order and presents it, with its offset and an error flag, to the cache fill (data SRAM write) path.
- Handles one line in flight; the miss path supplies the start offset before each burst.

---
 rtl/cc_line_deserializer_pkg.sv | 27 ++
 rtl/cc_line_deserializer.sv | 82 ++++++++
 tb/tb_cc_line_deserializer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/cc_line_deserializer_pkg.sv
// Shared constants, types and lane decode for the cache-controller line path.
// The receive side rebuilds a 512-bit line from a wrapping critical-word-first burst.
package cc_line_deserializer_pkg;

  localparam int BEAT_WIDTH = 64;
  localparam int NUM_BEATS  = 8;
  localparam int OFS_WIDTH  = 6;
  localparam int LINE_WIDTH = BEAT_WIDTH * NUM_BEATS;
  localparam int IDX_WIDTH  = $clog2(NUM_BEATS);

  typedef logic [NUM_BEATS-1:0][BEAT_WIDTH-1:0] line_t;
  typedef logic [IDX_WIDTH-1:0]                 beat_idx_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_FULL
  } state_t;

  localparam beat_idx_t LAST_BEAT = beat_idx_t'(NUM_BEATS - 1);

  // Start lane comes from the word-select bits of the offset; the add wraps mod NUM_BEATS.
  function automatic beat_idx_t lane_of(logic [OFS_WIDTH-1:0] ofs, beat_idx_t cnt);
    return ofs[OFS_WIDTH-1 -: IDX_WIDTH] + cnt;
  endfunction

endpackage

// File: rtl/cc_line_deserializer.sv
// Collects one wrapping R burst into a natural-order line and hands it to the fill path.
// Outputs are pure register / state decode; nothing combinational from inputs.
module cc_line_deserializer
  import cc_line_deserializer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ofs_valid_i,
  input  logic [OFS_WIDTH-1:0]  ofs_i,
  output logic                  ofs_ready_o,
  input  logic [BEAT_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_rlast_i,
  input  logic                  mem_rvalid_i,
  output logic                  mem_rready_o,
  output logic                  fill_valid_o,
  output logic [LINE_WIDTH-1:0] fill_data_o,
  output logic [OFS_WIDTH-1:0]  fill_ofs_o,
  output logic                  fill_err_o,
  input  logic                  fill_ready_i
);

  state_t               state_q, state_d;
  beat_idx_t            cnt_q;
  logic [OFS_WIDTH-1:0] ofs_q;
  logic                 err_q;
  line_t                lanes_q;

  logic beat_fire, last_beat;
  assign beat_fire = (state_q == S_COLLECT) && mem_rvalid_i;
  assign last_beat = (cnt_q == LAST_BEAT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    ofs_ready_o  = 1'b0;
    mem_rready_o = 1'b0;
    fill_valid_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        ofs_ready_o = 1'b1;
        if (ofs_valid_i) state_d = S_COLLECT;
      end
      S_COLLECT: begin
        mem_rready_o = 1'b1;
        // Either rlast or the eighth beat closes the line; mismatch is flagged as error.
        if (mem_rvalid_i && (mem_rlast_i || last_beat)) state_d = S_FULL;
      end
      S_FULL: begin
        fill_valid_o = 1'b1;
        if (fill_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      ofs_q   <= '0;
      err_q   <= 1'b0;
      lanes_q <= '0;
    end else if (state_q == S_IDLE && ofs_valid_i) begin
      cnt_q   <= '0;
      ofs_q   <= ofs_i;
      err_q   <= 1'b0;
      lanes_q <= '0;
    end else if (beat_fire) begin
      lanes_q[lane_of(ofs_q, cnt_q)] <= mem_rdata_i;
      cnt_q <= cnt_q + beat_idx_t'(1);
      if (mem_rlast_i != last_beat) err_q <= 1'b1;
    end
  end

  assign fill_data_o = lanes_q;
  assign fill_ofs_o  = ofs_q;
  assign fill_err_o  = err_q;

endmodule

// File: tb/tb_cc_line_deserializer.sv
// Directed bench for cc_line_deserializer: table of lines plus hand-written corner sequences.
module tb_cc_line_deserializer;
  import cc_line_deserializer_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  ofs_valid_i;
  logic [OFS_WIDTH-1:0]  ofs_i;
  logic                  ofs_ready_o;
  logic [BEAT_WIDTH-1:0] mem_rdata_i;
  logic                  mem_rlast_i;
  logic                  mem_rvalid_i;
  logic                  mem_rready_o;
  logic                  fill_valid_o;
  logic [LINE_WIDTH-1:0] fill_data_o;
  logic [OFS_WIDTH-1:0]  fill_ofs_o;
  logic                  fill_err_o;
  logic                  fill_ready_i;

  cc_line_deserializer dut (
    .clk(clk), .rst(rst),
    .ofs_valid_i(ofs_valid_i), .ofs_i(ofs_i), .ofs_ready_o(ofs_ready_o),
    .mem_rdata_i(mem_rdata_i), .mem_rlast_i(mem_rlast_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rready_o(mem_rready_o),
    .fill_valid_o(fill_valid_o), .fill_data_o(fill_data_o),
    .fill_ofs_o(fill_ofs_o), .fill_err_o(fill_err_o), .fill_ready_i(fill_ready_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OFS_WIDTH-1:0] ofs;
    int                   rlast_at;  // beat index carrying rlast; 8 means never
    logic                 exp_err;
  } vec_t;

  vec_t vecs[6];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [LINE_WIDTH-1:0] act,
                     input logic [LINE_WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic [BEAT_WIDTH-1:0] beat_val(int v, int k);
    return {16'hBEEF, 8'(v), 8'(k), 32'h1111_1111 * 32'(k + 1)};
  endfunction

  // Expected line: beat k lands in lane (start + k) mod 8; untouched lanes are zero.
  function automatic logic [LINE_WIDTH-1:0] model(logic [OFS_WIDTH-1:0] ofs, int nb, int v);
    logic [NUM_BEATS-1:0][BEAT_WIDTH-1:0] l;
    int start;
    l = '0;
    start = int'(ofs[5:3]);
    for (int k = 0; k < nb; k++) l[(start + k) % NUM_BEATS] = beat_val(v, k);
    return l;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_ofs(input logic [OFS_WIDTH-1:0] o);
    int n = 0;
    while (!ofs_ready_o && n < 20) begin tick(); n++; end
    chk("ofs_ready_wait", ofs_ready_o, 1'b1);
    ofs_valid_i = 1'b1;
    ofs_i       = o;
    tick();
    ofs_valid_i = 1'b0;
    chk("rready_in_collect", mem_rready_o, 1'b1);
    chk("ofs_ready_in_collect", ofs_ready_o, 1'b0);
  endtask

  task automatic send_beat(input logic [BEAT_WIDTH-1:0] d, input logic last);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = d;
    mem_rlast_i  = last;
    tick();
    mem_rvalid_i = 1'b0;
    mem_rlast_i  = 1'b0;
  endtask

  task automatic check_fill(input logic [LINE_WIDTH-1:0] d, input logic [OFS_WIDTH-1:0] o,
                            input logic e);
    chk("fill_valid", fill_valid_o, 1'b1);
    chk("fill_data", fill_data_o, d);
    chk("fill_ofs", fill_ofs_o, o);
    chk("fill_err", fill_err_o, e);
    chk("rready_in_full", mem_rready_o, 1'b0);
    chk("ofs_ready_in_full", ofs_ready_o, 1'b0);
  endtask

  task automatic release_fill();
    fill_ready_i = 1'b1;
    tick();
    fill_ready_i = 1'b0;
    chk("fill_valid_after_ready", fill_valid_o, 1'b0);
    chk("ofs_ready_after_fill", ofs_ready_o, 1'b1);
  endtask

  task automatic run_line(input logic [OFS_WIDTH-1:0] o, input int rlast_at,
                          input logic exp_err, input int v);
    int nb;
    logic [LINE_WIDTH-1:0] exp_line;
    nb = (rlast_at < NUM_BEATS) ? rlast_at + 1 : NUM_BEATS;
    exp_line = model(o, nb, v);
    send_ofs(o);
    for (int k = 0; k < nb; k++) begin
      chk("rready_per_beat", mem_rready_o, 1'b1);
      send_beat(beat_val(v, k), k == rlast_at);
    end
    check_fill(exp_line, o, exp_err);
    if (rlast_at >= NUM_BEATS) begin
      // A ninth beat must be refused and must not disturb the line.
      send_beat(64'hDEAD_DEAD_DEAD_DEAD, 1'b1);
      chk("ninth_beat_ignored", fill_data_o, exp_line);
      chk("rready_after_ninth", mem_rready_o, 1'b0);
    end
    release_fill();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ofs_ready"}, ofs_ready_o, 1'b1);
    chk({tag, "_rready"}, mem_rready_o, 1'b0);
    chk({tag, "_fill_valid"}, fill_valid_o, 1'b0);
    chk({tag, "_fill_data"}, fill_data_o, '0);
    chk({tag, "_fill_ofs"}, fill_ofs_o, '0);
    chk({tag, "_fill_err"}, fill_err_o, 1'b0);
  endtask

  initial begin
    logic [LINE_WIDTH-1:0] exp_line;

    vecs[0] = '{ofs: 6'h00, rlast_at: 7, exp_err: 1'b0};  // aligned
    vecs[1] = '{ofs: 6'h28, rlast_at: 7, exp_err: 1'b0};  // wraps from lane 5
    vecs[2] = '{ofs: 6'h10, rlast_at: 2, exp_err: 1'b1};  // early rlast, lanes 2..4
    vecs[3] = '{ofs: 6'h3F, rlast_at: 7, exp_err: 1'b0};  // lane 7 start, low bits kept
    vecs[4] = '{ofs: 6'h08, rlast_at: 8, exp_err: 1'b1};  // rlast never comes
    vecs[5] = '{ofs: 6'h30, rlast_at: 0, exp_err: 1'b1};  // single-beat burst

    rst = 1'b1;
    ofs_valid_i = 1'b0; ofs_i = '0;
    mem_rdata_i = '0; mem_rlast_i = 1'b0; mem_rvalid_i = 1'b0;
    fill_ready_i = 1'b0;
    #12;
    check_reset_outputs("reset");
    tick();
    rst = 1'b0;

    // fill_ready and rvalid outside their states must do nothing
    fill_ready_i = 1'b1; mem_rvalid_i = 1'b1; mem_rlast_i = 1'b1;
    tick();
    fill_ready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rlast_i = 1'b0;
    check_reset_outputs("idle_noise");

    for (int i = 0; i < 6; i++) run_line(vecs[i].ofs, vecs[i].rlast_at, vecs[i].exp_err, i);

    // Bubbles, held fill, and an offset presented while busy
    exp_line = model(6'h18, 8, 11);
    send_ofs(6'h18);
    ofs_valid_i = 1'b1;
    ofs_i       = 6'h3C;
    for (int k = 0; k < 8; k++) begin
      send_beat(beat_val(11, k), k == 7);
      if (k < 7) begin
        tick();
        chk("bubble_rready", mem_rready_o, 1'b1);
      end
    end
    check_fill(exp_line, 6'h18, 1'b0);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("held_valid", fill_valid_o, 1'b1);
      chk("held_data", fill_data_o, exp_line);
      chk("held_ofs", fill_ofs_o, 6'h18);
      chk("held_ofs_ready", ofs_ready_o, 1'b0);
    end
    release_fill();
    tick();  // pending offset 0x3C is taken now
    ofs_valid_i = 1'b0;
    chk("pending_ofs_taken", mem_rready_o, 1'b1);
    for (int k = 0; k < 8; k++) send_beat(beat_val(12, k), k == 7);
    check_fill(model(6'h3C, 8, 12), 6'h3C, 1'b0);
    release_fill();

    // Reset mid-burst drops the line asynchronously
    send_ofs(6'h20);
    for (int k = 0; k < 4; k++) send_beat(beat_val(13, k), 1'b0);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("mid_burst_reset");
    tick();
    rst = 1'b0;
    run_line(6'h38, 7, 1'b0, 14);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
